timer_arbiter: RTL
==================

# timer_arbiter

Round-robin arbiter and sequencer that shares a single wrap-to-0 cycle counter among `NUM_REQ` requesters. Each requester asks for a delay of N clock cycles. The block grants the counter to one requester at a time, runs the count, and pulses that requester's `done` when the delay expires. It sits between the protocol-level FSMs (bit/byte timers, timeout watchdogs) and the counter datapath, so the design does not need one counter per client.

## Interface
- `NUM_REQ`, default 4: number of requesters, minimum 2.
- `NUM_CNT_BITS`, default 8: counter and delay width.
- `PTR_BITS`, default `$clog2(NUM_REQ)`: round-robin pointer width, derived and not overridden.

Ports:
- `clk`, input, 1: clock, rising edge.
- `n_rst`, input, 1: reset, asynchronous, active-low.
- `req`, input, `NUM_REQ`: per-requester level request, held until `done` or abort.
- `delay`, input, `NUM_REQ*NUM_CNT_BITS`: packed per-requester delay. Requester i uses bits `[i*NUM_CNT_BITS +: NUM_CNT_BITS]`.
- `grant`, output, `NUM_REQ`: one-hot (or zero) owner of the counter, registered.
- `done`, output, `NUM_REQ`: one-cycle pulse to the owner when its delay expires.
- `busy`, output, 1: high whenever the FSM is not IDLE.
- `count_out`, output, `NUM_CNT_BITS`: current shared counter value.

## Operation
- FSM states:
  - IDLE: counter 0, no grant.
  - RUN: counting.
  - DONE: expiry cycle.
- Arbitration happens only in IDLE.
  - Search order starts at `(ptr+1) mod NUM_REQ` and wraps.
  - The first asserted `req` wins.
  - `ptr` is loaded with the winner index on the grant edge.
- On the grant edge the winner's `delay` is latched into `dly_q`. Later changes to `delay` are ignored until the next grant.
- IDLE state transitions:
  - No request: stay in IDLE.
  - Winner with `dly == 0`: go to DONE.
  - Otherwise: go to RUN. Counter = 0 and `grant[winner]` = 1.
- RUN:
  - `count_nxt = count + 1`.
  - If `count_nxt == dly_q`, go to DONE.
  - Counter arithmetic is unsigned `NUM_CNT_BITS`. Since `dly_q ≥ 1`, it never overflows.
- DONE:
  - `done[winner] = 1` and `grant` is still held.
  - The next edge goes to IDLE, clears the counter to 0 and drops `grant`.
- Abort: if `req[winner]` is 0 in RUN, the next edge goes to IDLE.
  - Counter is cleared and `grant` dropped.
  - No `done` pulse is issued.
  - `ptr` keeps the aborted winner.
- Dropping `req` while in DONE has no effect: `done` still pulses.
- Requests from non-owners are ignored while `busy`. They are arbitrated at the next IDLE cycle.
- Reset values:
  - FSM = IDLE.
  - `count_out` = 0, `grant` = 0, `done` = 0, `busy` = 0.
  - `ptr` = `NUM_REQ-1`, so requester 0 has first priority.
  - `dly_q` = 0.

## Timing
- `req` sampled at edge E means `grant` is high from E onward.
- For delay D, `grant` stays high for exactly D+1 cycles. `count_out` steps 0,1,…,D.
- `done` is high in the last grant cycle, when `count_out == D`. For D = 0, `done` is high in the single grant cycle.
- `grant` falls at edge E+D+1.
- Earliest re-grant is edge E+D+2. This leaves one mandatory IDLE cycle between owners.
- Back-to-back requests from the same requester therefore recur every D+2 cycles.
- Abort latency: `req` low sampled at edge A means `grant` = 0 and counter = 0 after A.
- All outputs are registered or decoded from registered state only. There is no combinational `req`→`grant` path.
- Asserting `n_rst` mid-RUN forces all reset values immediately, with no `done`. After release, arbitration resumes at the first edge.

## Test plan
1. Reset, then `req` = 4'b0001 with delay0 = 5.
   - `grant` = 0001 for 6 cycles, `count_out` 0..5.
   - `done[0]` high exactly when `count_out` = 5.
   - `busy` drops the cycle after.
2. All four `req` held constant, all delays = 2.
   - Grants rotate in order 0,1,2,3,0.
   - Each grant lasts 3 cycles, separated by one IDLE cycle.
   - Four `done` pulses in order.
3. `req` = 0010, delay1 = 0.
   - `grant` = 0010 and `done` = 0010 in the same single cycle.
   - Counter stays 0. Next grant is possible 2 cycles after the first.
4. Abort: delay2 = 10, deassert `req[2]` when `count_out` = 4.
   - Next cycle `grant` = 0 and `count_out` = 0, with no `done`.
   - A pending `req[3]` is granted one edge later.
5. Change delay0 from 5 to 1 during RUN.
   - Expiry still occurs at `count_out` = 5.
   - Also: `delay` = 255 with 8 bits counts to 255 without wrap. `done` fires at 255 and the counter returns to 0.
6. Assert `n_rst` when `count_out` = 3.
   - All outputs go to 0 asynchronously and no `done` is issued.
   - After release with `req` = 1111, requester 0 is granted first.

Source files
------------

// File: rtl/timer_arbiter.sv
// Round-robin owner of one shared wrap-to-0 delay counter: grants a requester,
// counts its latched delay, pulses its done on expiry, then idles one cycle.
module timer_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_CNT_BITS = 8,
  parameter int PTR_BITS     = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*NUM_CNT_BITS-1:0]   delay,
  output logic [NUM_REQ-1:0]                grant,
  output logic [NUM_REQ-1:0]                done,
  output logic                              busy,
  output logic [NUM_CNT_BITS-1:0]           count_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [PTR_BITS-1:0]     r_ptr;
  logic [NUM_CNT_BITS-1:0] r_dly;
  logic [NUM_CNT_BITS-1:0] r_count;
  logic [NUM_REQ-1:0]      r_grant;
  logic [NUM_REQ-1:0]      r_done;
  logic                    r_busy;

  logic                    w_found;
  logic [PTR_BITS-1:0]     w_win;
  logic [PTR_BITS:0]       w_sum;
  logic [NUM_CNT_BITS-1:0] w_dly;
  logic [NUM_CNT_BITS-1:0] w_count_nxt;
  logic [NUM_REQ-1:0]      w_win_oh;

  // Search starts one past the last winner; the extra sum bit absorbs the wrap.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_sum   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PTR_BITS+1)'(k);
      if (w_sum >= (PTR_BITS+1)'(NUM_REQ))
        w_sum = w_sum - (PTR_BITS+1)'(NUM_REQ);
      if (!w_found && req[w_sum[PTR_BITS-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[PTR_BITS-1:0];
      end
    end
  end

  assign w_dly       = delay[w_win*NUM_CNT_BITS +: NUM_CNT_BITS];
  assign w_count_nxt = r_count + NUM_CNT_BITS'(1);
  assign w_win_oh    = NUM_REQ'(1) << w_win;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_ptr   <= PTR_BITS'(NUM_REQ-1);
      r_dly   <= '0;
      r_count <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_ptr   <= w_win;
            r_dly   <= w_dly;
            r_count <= '0;
            r_grant <= w_win_oh;
            r_busy  <= 1'b1;
            if (w_dly == '0) begin
              r_state <= S_DONE;
              r_done  <= w_win_oh;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // Abort wins over a simultaneous expiry: no done without a live request.
          if (!req[r_ptr]) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
          end else if (w_count_nxt == r_dly) begin
            r_state <= S_DONE;
            r_count <= w_count_nxt;
            r_done  <= r_grant;
          end else begin
            r_count <= w_count_nxt;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_count <= '0;
          r_grant <= '0;
          r_done  <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= '0;
          r_grant <= '0;
          r_done  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign busy      = r_busy;
  assign count_out = r_count;

endmodule
